// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: stage indices, result-ready codes, the
// forwarding encoding and the hazard tracker entry layout.
package mips_pkg;
  localparam int ST_EX      = 1;
  localparam int ST_MEM     = 2;
  localparam int READY_ALU  = 1;
  localparam int READY_LOAD = 2;
  localparam int FWD_RF     = 0;

  // Entry fields are sized for the widest legal configuration; narrower
  // instances zero-extend into them.
  localparam int REG_MAX = 8;
  localparam int SW_MAX  = 4;

  typedef struct packed {
    logic               valid;
    logic [REG_MAX-1:0] rgn;
    logic [SW_MAX-1:0]  rdy;
  } trk_ent_t;
endpackage

// File: rtl/pipe_hazard_unit_if.sv
// ID-side request and hazard/forward response bundle of the hazard unit.
interface pipe_hazard_unit_if #(
  parameter int REGBITS = 5,
  parameter int SW      = 3
);
  logic               id_valid;
  logic [REGBITS-1:0] id_rs, id_rt;
  logic               id_use_rs, id_use_rt;
  logic               id_wr_en;
  logic [REGBITS-1:0] id_wr_reg;
  logic [SW-1:0]      id_ready_stage;
  logic               redirect, freeze;

  logic               if_hold, id_hold, id_flush, ex_bubble;
  logic [SW-1:0]      ex_fwd_a, ex_fwd_b;
  logic [31:0]        stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_reg,
           id_ready_stage, redirect, freeze,
    input  if_hold, id_hold, id_flush, ex_bubble, ex_fwd_a, ex_fwd_b, stall_cnt
  );
  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_reg,
           id_ready_stage, redirect, freeze,
    output if_hold, id_hold, id_flush, ex_bubble, ex_fwd_a, ex_fwd_b, stall_cnt
  );
endinterface

// File: rtl/hazard_src_match.sv
// Youngest in-flight writer search for one ID source operand; reports whether
// its result is still pending (hazard) or which stage register to forward from.
module hazard_src_match
  import mips_pkg::*;
#(
  parameter int DEPTH   = 3,
  parameter int REGBITS = 5,
  parameter int SW      = 3
) (
  input  trk_ent_t [DEPTH-1:1] i_ent,
  input  logic [REGBITS-1:0]   i_src,
  input  logic                 i_use,
  output logic                 o_found,
  output logic [SW-1:0]        o_k,
  output logic                 o_hazard,
  output logic [SW-1:0]        o_fwd_sel
);
  logic [SW_MAX-1:0] w_rdy;

  always_comb begin
    o_found = 1'b0;
    o_k     = '0;
    w_rdy   = '0;
    // Scan oldest to youngest so the youngest hit is the one left standing.
    for (int k = DEPTH-1; k >= 1; k--) begin
      if (i_use && (i_src != '0) && i_ent[k].valid &&
          (i_ent[k].rgn == REG_MAX'(i_src))) begin
        o_found = 1'b1;
        o_k     = SW'(k);
        w_rdy   = i_ent[k].rdy;
      end
    end
  end

  assign o_hazard  = o_found && (SW_MAX'(o_k) < w_rdy);
  assign o_fwd_sel = (o_found && !o_hazard) ? o_k + SW'(1) : SW'(FWD_RF);
endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and flush controller: tracks in-flight register writes per
// stage and produces load/multi-cycle stalls, EX forward selects and flushes.
module pipe_hazard_unit
  import mips_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int REGBITS  = 5,
  parameter int BR_STAGE = 2,
  parameter int SW       = 3
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_unit_if.slave hz
);
  if (DEPTH < 3 || DEPTH > 8 || BR_STAGE < 1 || BR_STAGE > DEPTH-1 ||
      (1 << SW) <= DEPTH || SW > SW_MAX || REGBITS > REG_MAX) begin : g_bad_params
    $error("pipe_hazard_unit: illegal parameter set");
  end

  trk_ent_t [DEPTH:1] r_trk;
  logic [SW-1:0]      r_fwd_a, r_fwd_b;
  logic [31:0]        r_stall_cnt;

  logic          w_rs_found, w_rt_found, w_rs_haz, w_rt_haz;
  logic [SW-1:0] w_rs_k, w_rt_k, w_rs_fwd, w_rt_fwd, w_rdy;
  logic          w_stall, w_kill;
  trk_ent_t      w_new;
  logic          w_unused_k;

  hazard_src_match #(.DEPTH(DEPTH), .REGBITS(REGBITS), .SW(SW)) u_rs (
    .i_ent(r_trk[DEPTH-1:1]), .i_src(hz.id_rs), .i_use(hz.id_use_rs),
    .o_found(w_rs_found), .o_k(w_rs_k), .o_hazard(w_rs_haz), .o_fwd_sel(w_rs_fwd)
  );

  hazard_src_match #(.DEPTH(DEPTH), .REGBITS(REGBITS), .SW(SW)) u_rt (
    .i_ent(r_trk[DEPTH-1:1]), .i_src(hz.id_rt), .i_use(hz.id_use_rt),
    .o_found(w_rt_found), .o_k(w_rt_k), .o_hazard(w_rt_haz), .o_fwd_sel(w_rt_fwd)
  );

  assign w_unused_k = ^{w_rs_k, w_rt_k};

  assign w_stall = !reset && hz.id_valid && !hz.redirect && !hz.freeze &&
                   ((w_rs_found && w_rs_haz) || (w_rt_found && w_rt_haz));
  assign w_kill  = hz.redirect || w_stall;

  // An out-of-range ready stage would never resolve; treat it as the last one.
  assign w_rdy = (hz.id_ready_stage >= SW'(DEPTH)) ? SW'(DEPTH-1) : hz.id_ready_stage;

  always_comb begin
    w_new       = '0;
    w_new.valid = hz.id_valid && hz.id_wr_en && (hz.id_wr_reg != '0);
    w_new.rgn   = REG_MAX'(hz.id_wr_reg);
    w_new.rdy   = SW_MAX'(w_rdy);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_trk       <= '0;
      r_fwd_a     <= '0;
      r_fwd_b     <= '0;
      r_stall_cnt <= '0;
    end else if (!hz.freeze) begin
      for (int k = DEPTH; k >= 2; k--) begin
        r_trk[k] <= r_trk[k-1];
        // Work younger than the resolving branch is squashed as it moves on.
        if (hz.redirect && (k - 1) < BR_STAGE) r_trk[k].valid <= 1'b0;
      end
      r_trk[1] <= w_kill ? '0 : w_new;
      r_fwd_a  <= w_kill ? SW'(FWD_RF) : w_rs_fwd;
      r_fwd_b  <= w_kill ? SW'(FWD_RF) : w_rt_fwd;
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign hz.if_hold   = !reset && (hz.freeze || w_stall);
  assign hz.id_hold   = !reset && (hz.freeze || w_stall);
  assign hz.id_flush  = !reset && !hz.freeze && hz.redirect;
  assign hz.ex_bubble = !reset && !hz.freeze && (hz.redirect || w_stall);
  assign hz.ex_fwd_a  = r_fwd_a;
  assign hz.ex_fwd_b  = r_fwd_b;
  assign hz.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit: directed scenarios plus random traffic
// against a list-of-in-flight-writes reference model.
module tb_pipe_hazard_unit;
  localparam int DEPTH    = 5;
  localparam int REGBITS  = 5;
  localparam int BR_STAGE = 3;
  localparam int SW       = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_unit_if #(.REGBITS(REGBITS), .SW(SW)) hz ();

  pipe_hazard_unit #(.DEPTH(DEPTH), .REGBITS(REGBITS), .BR_STAGE(BR_STAGE), .SW(SW)) dut (
    .clk(clk), .reset(reset), .hz(hz)
  );

  typedef struct {
    bit rst, valid, urs, urt, wr, redirect, freeze;
    int rs, rt, wd, rdy;
  } stim_t;

  typedef struct {
    bit          if_hold, id_hold, id_flush, ex_bubble;
    int          fwd_a, fwd_b;
    logic [31:0] cnt;
  } exp_t;

  typedef struct { int rg; int rdy; int stage; } fl_t;

  fl_t         fl[$];
  exp_t        sbq[$];
  int          m_fwd_a, m_fwd_b;
  logic [31:0] m_cnt;
  bit          last_stall;
  int          errors = 0;
  int          checks = 0;

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, req, $time);
    end
  endfunction

  // Youngest in-flight writer of s still short of WB decides stall vs forward.
  function automatic void find(input int s, input bit u, output bit haz, output int fwd);
    int best, br;
    best = 0; br = 0; haz = 0; fwd = 0;
    if (!u || s == 0) return;
    foreach (fl[i])
      if (fl[i].stage < DEPTH && fl[i].rg == s && (best == 0 || fl[i].stage < best)) begin
        best = fl[i].stage;
        br   = fl[i].rdy;
      end
    if (best != 0) begin
      if (best < br) haz = 1;
      else           fwd = best + 1;
    end
  endfunction

  function automatic stim_t ins(int rs, bit urs, int rt, bit urt, bit wr, int wd, int rdy);
    stim_t s;
    s = '{default: 0};
    s.valid = 1; s.rs = rs; s.urs = urs; s.rt = rt; s.urt = urt;
    s.wr = wr; s.wd = wd; s.rdy = rdy;
    return s;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '{default: 0};
    s.rdy = 1;
    return s;
  endfunction

  task automatic go(input stim_t s);
    bit ha, hb, st;
    int fa, fb;
    exp_t e;
    @(negedge clk);
    assert (s.rdy < DEPTH) else $error("illegal ready stage %0d", s.rdy);
    reset = s.rst;
    hz.id_valid = s.valid;   hz.id_rs = REGBITS'(s.rs);   hz.id_rt = REGBITS'(s.rt);
    hz.id_use_rs = s.urs;    hz.id_use_rt = s.urt;        hz.id_wr_en = s.wr;
    hz.id_wr_reg = REGBITS'(s.wd); hz.id_ready_stage = SW'(s.rdy);
    hz.redirect = s.redirect; hz.freeze = s.freeze;

    find(s.rs, s.urs, ha, fa);
    find(s.rt, s.urt, hb, fb);
    st = !s.rst && s.valid && (ha || hb) && !s.redirect && !s.freeze;
    e.if_hold   = !s.rst && (s.freeze || st);
    e.id_hold   = e.if_hold;
    e.id_flush  = !s.rst && !s.freeze && s.redirect;
    e.ex_bubble = !s.rst && !s.freeze && (s.redirect || st);
    e.fwd_a = m_fwd_a; e.fwd_b = m_fwd_b; e.cnt = m_cnt;
    sbq.push_back(e);
    last_stall = st;

    if (s.rst) begin
      fl.delete(); m_fwd_a = 0; m_fwd_b = 0; m_cnt = '0;
    end else if (!s.freeze) begin
      if (s.redirect) fl = fl.find(x) with (x.stage >= BR_STAGE);
      foreach (fl[i]) fl[i].stage++;
      fl = fl.find(x) with (x.stage <= DEPTH);
      if (!s.redirect && !st && s.valid && s.wr && s.wd != 0)
        fl.push_front('{s.wd, s.rdy, 1});
      m_fwd_a = (s.redirect || st) ? 0 : fa;
      m_fwd_b = (s.redirect || st) ? 0 : fb;
      if (st && m_cnt != '1) m_cnt++;
    end
  endtask

  // Present one instruction until the model no longer predicts a stall.
  task automatic go_hold(input stim_t s);
    int n = 0;
    do begin go(s); n++; end while (last_stall && n < 12);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) go(nop());
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("if_hold",   32'(hz.if_hold),   32'(e.if_hold));
        chk("id_hold",   32'(hz.id_hold),   32'(e.id_hold));
        chk("id_flush",  32'(hz.id_flush),  32'(e.id_flush));
        chk("ex_bubble", 32'(hz.ex_bubble), 32'(e.ex_bubble));
        chk("ex_fwd_a",  32'(hz.ex_fwd_a),  32'(e.fwd_a));
        chk("ex_fwd_b",  32'(hz.ex_fwd_b),  32'(e.fwd_b));
        chk("stall_cnt", hz.stall_cnt,      e.cnt);
      end
    end
  end

  initial begin : driver
    stim_t s;
    reset = 1'b1;
    hz.id_valid = 0; hz.id_rs = '0; hz.id_rt = '0; hz.id_use_rs = 0; hz.id_use_rt = 0;
    hz.id_wr_en = 0; hz.id_wr_reg = '0; hz.id_ready_stage = SW'(1);
    hz.redirect = 0; hz.freeze = 0;
    m_fwd_a = 0; m_fwd_b = 0; m_cnt = '0; last_stall = 0;
    repeat (2) @(posedge clk);
    idle(2);

    // ALU producer, back-to-back and one-apart consumers
    go(ins(0, 0, 0, 0, 1, 2, 1));
    go(ins(2, 1, 0, 0, 1, 6, 1));
    go(ins(2, 1, 0, 0, 0, 0, 1));
    idle(5);

    // load-use on rt
    go(ins(0, 0, 0, 0, 1, 3, 2));
    go_hold(ins(0, 0, 3, 1, 0, 0, 1));
    idle(5);

    // long-latency producer
    go(ins(0, 0, 0, 0, 1, 9, 3));
    go_hold(ins(9, 1, 9, 1, 0, 0, 1));
    idle(5);

    // redirect squashes a young load
    go(ins(0, 0, 0, 0, 1, 4, 2));
    s = ins(4, 1, 0, 0, 0, 0, 1); s.redirect = 1; go(s);
    go_hold(ins(4, 1, 4, 1, 0, 0, 1));
    idle(5);

    // freeze across a load-use hazard
    go(ins(0, 0, 0, 0, 1, 7, 2));
    s = ins(7, 1, 0, 0, 0, 0, 1); s.freeze = 1;
    repeat (4) go(s);
    go_hold(ins(7, 1, 0, 0, 0, 0, 1));
    idle(5);

    // $0 never tracked; youngest of two $5 writers wins
    go(ins(0, 0, 0, 0, 1, 0, 1));
    go(ins(0, 0, 0, 0, 1, 5, 1));
    go(ins(0, 0, 0, 0, 1, 5, 1));
    go(ins(5, 1, 0, 1, 0, 0, 1));
    idle(5);

    // reset while stalled
    go(ins(0, 0, 0, 0, 1, 8, 4));
    go(ins(8, 1, 0, 0, 0, 0, 1));
    s = ins(8, 1, 0, 0, 0, 0, 1); s.rst = 1; go(s);
    idle(3);

    // random traffic; a stalled instruction is re-presented like real ID
    s = nop();
    for (int i = 0; i < 800; i++) begin
      if (!last_stall || s.rst) begin
        s = ins($urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
                1'($urandom), $urandom_range(0, 7),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, DEPTH-1) : $urandom_range(1, 2));
        s.valid = ($urandom_range(0, 7) != 0);
      end
      s.redirect = ($urandom_range(0, 9) == 0);
      s.freeze   = ($urandom_range(0, 9) == 0);
      s.rst      = ($urandom_range(0, 99) == 0);
      go(s);
    end
    idle(3);

    repeat (4) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
